// File: rtl/lsu_pkg.sv
// Shared types and the alignment rule for the core0 load/store memory master.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ACCESS    = 3'd1,
        ST_RMW_READ  = 3'd2,
        ST_RMW_WRITE = 3'd3,
        ST_RESP      = 3'd4
    } state_e;

    // Reserved size is never legal; halves need even, words need 4-byte alignment.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = addr_lo[0];
            SZ_W:    bad = |addr_lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Execute-stage request/response handshake plus the word-addressed memory port.
interface lsu_mem_master_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_w_en;
    logic [31:0] mem_read_data;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_address, mem_write_data, mem_w_en,
        input  mem_read_data
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_address, mem_write_data, mem_w_en,
        output mem_read_data
    );

endinterface

// File: rtl/lsu_byte_lane.sv
// Lane steering: load extract with sign/zero extension, and sub-word store merge.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] i_rd_word,
    input  logic [1:0]  i_addr_lo,
    input  size_e       i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_data
);

    logic [4:0]  w_sh_b;
    logic [4:0]  w_sh_h;
    logic [31:0] w_word_b;
    logic [31:0] w_word_h;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_ext_b;
    logic        w_ext_h;
    logic [31:0] w_mask;
    logic [31:0] w_ins;

    // Select the addressed lane and extend it to a full word.
    always_comb begin
        w_sh_b   = {i_addr_lo, 3'b000};
        w_sh_h   = {i_addr_lo[1], 4'b0000};
        w_word_b = i_rd_word >> w_sh_b;
        w_word_h = i_rd_word >> w_sh_h;
        w_byte   = w_word_b[7:0];
        w_half   = w_word_h[15:0];
        w_ext_b  = ~i_unsigned & w_byte[7];
        w_ext_h  = ~i_unsigned & w_half[15];
        case (i_size)
            SZ_B:    o_load_data = {{24{w_ext_b}}, w_byte};
            SZ_H:    o_load_data = {{16{w_ext_h}}, w_half};
            default: o_load_data = i_rd_word;
        endcase
    end

    // Replace only the addressed lane of the previously read word.
    always_comb begin
        case (i_size)
            SZ_B: begin
                w_mask = 32'h0000_00FF << w_sh_b;
                w_ins  = {24'd0, i_wdata[7:0]} << w_sh_b;
            end
            SZ_H: begin
                w_mask = 32'h0000_FFFF << w_sh_h;
                w_ins  = {16'd0, i_wdata[15:0]} << w_sh_h;
            end
            default: begin
                w_mask = 32'hFFFF_FFFF;
                w_ins  = i_wdata;
            end
        endcase
        o_merge_data = (i_rd_word & ~w_mask) | (w_ins & w_mask);
    end

endmodule

// File: rtl/lsu_mem_master.sv
// core0 data-memory initiator: one request at a time, sub-word stores via read-modify-write.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter bit STORE_RMW = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    lsu_mem_master_if.master bus
);

    state_e      r_state;
    state_e      w_next_state;

    logic        r_req_ready;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;
    logic        r_mem_w_en;
    logic [31:0] r_mem_address;
    logic [31:0] r_mem_wdata;

    logic        r_we;
    logic        r_unsigned;
    logic [1:0]  r_addr_lo;
    size_e       r_size;
    logic [31:0] r_wdata;

    size_e       w_req_size;
    logic        w_accept;
    logic        w_subword_store;
    logic        w_req_err;
    logic        w_req_ready_nxt;
    logic        w_rsp_valid_nxt;
    logic        w_mem_w_en_nxt;
    logic [31:0] w_load_data;
    logic [31:0] w_merge_data;

    // Request decode; errors are decided here so they never reach the memory port.
    always_comb begin
        w_req_size      = size_e'(bus.req_size);
        w_accept        = bus.req_valid && r_req_ready;
        w_subword_store = bus.req_we && ((w_req_size == SZ_B) || (w_req_size == SZ_H));
        w_req_err       = is_misaligned(w_req_size, bus.req_addr[1:0])
                          || (!STORE_RMW && w_subword_store);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_accept) begin
                    w_next_state = ST_IDLE;
                end else if (w_req_err) begin
                    w_next_state = ST_RESP;
                end else if (w_subword_store) begin
                    w_next_state = ST_RMW_READ;
                end else begin
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS:    w_next_state = ST_RESP;
            ST_RMW_READ:  w_next_state = ST_RMW_WRITE;
            ST_RMW_WRITE: w_next_state = ST_RESP;
            ST_RESP:      w_next_state = ST_IDLE;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every strobe leaves a flop.
    always_comb begin
        w_req_ready_nxt = (w_next_state == ST_IDLE);
        w_rsp_valid_nxt = (w_next_state == ST_RESP);
        w_mem_w_en_nxt  = (w_next_state == ST_RMW_WRITE)
                          || ((w_next_state == ST_ACCESS) && bus.req_we);
    end

    lsu_byte_lane u_lane (
        .i_rd_word    (bus.mem_read_data),
        .i_addr_lo    (r_addr_lo),
        .i_size       (r_size),
        .i_unsigned   (r_unsigned),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    // Request latch, memory-port registers and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_err     <= 1'b0;
            r_rsp_rdata   <= 32'd0;
            r_mem_w_en    <= 1'b0;
            r_mem_address <= 32'd0;
            r_mem_wdata   <= 32'd0;
            r_we          <= 1'b0;
            r_unsigned    <= 1'b0;
            r_addr_lo     <= 2'b00;
            r_size        <= SZ_B;
            r_wdata       <= 32'd0;
        end else begin
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_mem_w_en  <= w_mem_w_en_nxt;
            if (w_accept) begin
                r_we       <= bus.req_we;
                r_unsigned <= bus.req_unsigned;
                r_addr_lo  <= bus.req_addr[1:0];
                r_size     <= w_req_size;
                r_wdata    <= bus.req_wdata;
                // A rejected request leaves the memory port untouched.
                if (!w_req_err) begin
                    r_mem_address <= {bus.req_addr[31:2], 2'b00};
                end
                if (!w_req_err && bus.req_we && (w_req_size == SZ_W)) begin
                    r_mem_wdata <= bus.req_wdata;
                end
            end
            if (r_state == ST_RMW_READ) begin
                r_mem_wdata <= w_merge_data;
            end
            if (w_next_state == ST_RESP) begin
                r_rsp_err   <= (r_state == ST_IDLE);
                r_rsp_rdata <= ((r_state == ST_ACCESS) && !r_we) ? w_load_data : 32'd0;
            end
        end
    end

    assign bus.req_ready      = r_req_ready;
    assign bus.rsp_valid      = r_rsp_valid;
    assign bus.rsp_err        = r_rsp_err;
    assign bus.rsp_rdata      = r_rsp_rdata;
    assign bus.mem_address    = r_mem_address;
    assign bus.mem_write_data = r_mem_wdata;
    assign bus.mem_w_en       = r_mem_w_en & rst_n;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Randomized and directed bench for lsu_mem_master against a request-level reference model.
module tb_lsu_mem_master;

    localparam logic [31:0] B_WORD = 32'hA5A5_5AC3;

    int n_vec = 0;
    int n_err = 0;
    int wen_a = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic preload = 1'b1;

    logic [31:0] mem_env [0:63];
    logic [31:0] ref_mem [0:63];

    lsu_mem_master_if if_a ();
    lsu_mem_master_if if_b ();

    lsu_mem_master #(.STORE_RMW(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    lsu_mem_master #(.STORE_RMW(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'h8899_AABB : ((32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
    endfunction

    // Environment memory: combinational read, written on the clock edge.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem_env[i] <= init_word(i);
        end else if (if_a.mem_w_en) begin
            mem_env[if_a.mem_address[7:2]] <= if_a.mem_write_data;
        end
    end

    assign if_a.mem_read_data = mem_env[if_a.mem_address[7:2]];
    assign if_b.mem_read_data = B_WORD;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (if_a.mem_w_en) wen_a++;
        if (!rst_n) check_val("wen_in_reset", 32'(if_a.mem_w_en), 32'd0);
    end

    // Request-level model: the word is treated as four bytes.
    function automatic void ref_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                    input logic uns, input logic [31:0] wdata, input bit rmw,
                                    input logic [31:0] word, output logic err,
                                    output logic [31:0] rdata, output logic [31:0] new_word,
                                    output int lat);
        logic [7:0] b [4];
        int off;
        int val;
        for (int k = 0; k < 4; k++) b[k] = 8'((word >> (8 * k)) & 32'hFF);
        off = int'(addr[1:0]);
        err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0)
              || (!rmw && we && size != 2'd2);
        rdata = 32'd0;
        new_word = word;
        if (err) begin
            lat = 1;
        end else if (!we) begin
            lat = 2;
            if (size == 2'd0) begin
                val = int'(b[off]);
                if (!uns && val >= 128) val -= 256;
                rdata = 32'(val);
            end else if (size == 2'd1) begin
                val = int'(b[off]) + 256 * int'(b[off + 1]);
                if (!uns && val >= 32768) val -= 65536;
                rdata = 32'(val);
            end else begin
                rdata = word;
            end
        end else begin
            lat = (size == 2'd2) ? 2 : 3;
            b[off] = wdata[7:0];
            if (size != 2'd0) b[off + 1] = wdata[15:8];
            if (size == 2'd2) begin
                b[2] = wdata[23:16];
                b[3] = wdata[31:24];
            end
            new_word = {b[3], b[2], b[1], b[0]};
        end
    endfunction

    task automatic set_req(input bit va, input bit vb, input logic we, input logic [31:0] addr,
                           input logic [1:0] size, input logic uns, input logic [31:0] wdata);
        if_a.req_valid = va;  if_a.req_we = we;  if_a.req_addr = addr;
        if_a.req_size = size; if_a.req_unsigned = uns; if_a.req_wdata = wdata;
        if_b.req_valid = vb;  if_b.req_we = we;  if_b.req_addr = addr;
        if_b.req_size = size; if_b.req_unsigned = uns; if_b.req_wdata = wdata;
    endtask

    // One request to both masters; each is checked against its own expectation.
    task automatic run_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata, output logic [31:0] rd_out);
        int idx;
        logic ea_err, eb_err;
        logic [31:0] ea_rd, eb_rd, ea_new, eb_new;
        int ea_lat, eb_lat;
        int la, lb, nwa, nwb, nra, nrb, wca;
        logic [31:0] wda, waa, rda, rdb;
        logic era, erb;
        idx = int'(addr[7:2]);
        ref_req(we, addr, size, uns, wdata, 1'b1, ref_mem[idx], ea_err, ea_rd, ea_new, ea_lat);
        ref_req(we, addr, size, uns, wdata, 1'b0, B_WORD, eb_err, eb_rd, eb_new, eb_lat);
        @(negedge clk);
        set_req(1'b1, 1'b1, we, addr, size, uns, wdata);
        check_val("ready_a", 32'(if_a.req_ready), 32'd1);
        check_val("ready_b", 32'(if_b.req_ready), 32'd1);
        @(posedge clk);
        #1;
        if_a.req_valid = 1'b0;
        if_b.req_valid = 1'b0;
        la = 0; lb = 0; nwa = 0; nwb = 0; nra = 0; nrb = 0; wca = 0;
        wda = 32'd0; waa = 32'd0; rda = 32'd0; rdb = 32'd0; era = 1'b0; erb = 1'b0;
        for (int c = 1; c <= 8 && (la == 0 || lb == 0); c++) begin
            @(negedge clk);
            if (if_a.mem_w_en) begin
                nwa++; wca = c; wda = if_a.mem_write_data; waa = if_a.mem_address;
            end
            if (if_b.mem_w_en) nwb++;
            if (if_a.rsp_valid) begin
                nra++;
                if (la == 0) begin la = c; era = if_a.rsp_err; rda = if_a.rsp_rdata; end
            end
            if (if_b.rsp_valid) begin
                nrb++;
                if (lb == 0) begin lb = c; erb = if_b.rsp_err; rdb = if_b.rsp_rdata; end
            end
        end
        check_val("lat_a", 32'(la), 32'(ea_lat));
        check_val("err_a", 32'(era), 32'(ea_err));
        check_val("rdata_a", rda, ea_rd);
        check_val("wen_cnt_a", 32'(nwa), (we && !ea_err) ? 32'd1 : 32'd0);
        check_val("rsp_cnt_a", 32'(nra), 32'd1);
        check_val("lat_b", 32'(lb), 32'(eb_lat));
        check_val("err_b", 32'(erb), 32'(eb_err));
        check_val("rdata_b", rdb, eb_rd);
        check_val("wen_cnt_b", 32'(nwb), (we && !eb_err) ? 32'd1 : 32'd0);
        check_val("rsp_cnt_b", 32'(nrb), 32'd1);
        if (we && !ea_err) begin
            check_val("wen_cycle_a", 32'(wca), 32'(ea_lat - 1));
            check_val("wr_data_a", wda, ea_new);
            check_val("wr_addr_a", waa, {addr[31:2], 2'b00});
            ref_mem[idx] = ea_new;
        end
        @(negedge clk);
        check_val("rsp_pulse_a", 32'(if_a.rsp_valid), 32'd0);
        check_val("ready_back_a", 32'(if_a.req_ready), 32'd1);
        check_val("ready_back_b", 32'(if_b.req_ready), 32'd1);
        rd_out = rda;
    endtask

    logic [31:0] rd;
    logic [31:0] h_addr [3];
    logic [1:0]  h_size [3];
    logic        h_uns  [3];
    logic [31:0] h_exp  [3];
    int h_tacc [3];
    int h_trsp [3];

    initial begin
        int w0;
        int acc, got, rdy_cnt;
        bit take;
        logic e_err;
        logic [31:0] e_new;
        int e_lat;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        set_req(1'b0, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
        repeat (3) @(negedge clk);
        check_val("rst_ready", 32'(if_a.req_ready), 32'd1);
        check_val("rst_rsp_valid", 32'(if_a.rsp_valid), 32'd0);
        check_val("rst_rdata", if_a.rsp_rdata, 32'd0);
        check_val("rst_err", 32'(if_a.rsp_err), 32'd0);
        check_val("rst_wen", 32'(if_a.mem_w_en), 32'd0);
        check_val("rst_addr", if_a.mem_address, 32'd0);
        check_val("rst_wdata", if_a.mem_write_data, 32'd0);
        preload = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_ready", 32'(if_a.req_ready), 32'd1);

        run_req(1'b0, 32'h13, 2'd0, 1'b0, 32'd0, rd);  check_val("lb_13", rd, 32'hFFFF_FF88);
        run_req(1'b0, 32'h12, 2'd0, 1'b1, 32'd0, rd);  check_val("lbu_12", rd, 32'h0000_0099);
        run_req(1'b0, 32'h12, 2'd1, 1'b0, 32'd0, rd);  check_val("lh_12", rd, 32'hFFFF_8899);
        run_req(1'b1, 32'h11, 2'd0, 1'b0, 32'h1234_56CC, rd);
        run_req(1'b0, 32'h10, 2'd2, 1'b0, 32'd0, rd);  check_val("lw_10", rd, 32'h8899_CCBB);
        run_req(1'b1, 32'h20, 2'd2, 1'b0, 32'hDEAD_BEEF, rd);
        run_req(1'b0, 32'h20, 2'd2, 1'b0, 32'd0, rd);  check_val("lw_20", rd, 32'hDEAD_BEEF);
        run_req(1'b0, 32'h11, 2'd1, 1'b0, 32'd0, rd);  check_val("lh_11_rd", rd, 32'd0);
        run_req(1'b1, 32'h22, 2'd2, 1'b0, 32'h0BAD_F00D, rd);
        run_req(1'b0, 32'h04, 2'd3, 1'b0, 32'd0, rd);  check_val("rsv_rd", rd, 32'd0);

        // Reset lands while the halfword store is in its read phase.
        @(negedge clk);
        set_req(1'b1, 1'b0, 1'b1, 32'h12, 2'd1, 1'b0, 32'hCAFE_1234);
        @(posedge clk);
        #1;
        if_a.req_valid = 1'b0;
        w0 = wen_a;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_val("rst_mid_rsp", 32'(if_a.rsp_valid), 32'd0);
            check_val("rst_mid_wen", 32'(if_a.mem_w_en), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_mid_ready", 32'(if_a.req_ready), 32'd1);
        check_val("rst_mid_rsp2", 32'(if_a.rsp_valid), 32'd0);
        check_val("rst_mid_wcount", 32'(wen_a), 32'(w0));
        run_req(1'b0, 32'h10, 2'd2, 1'b0, 32'd0, rd);

        // Three loads with req_valid held high.
        h_addr = '{32'h10, 32'h13, 32'h12};
        h_size = '{2'd2, 2'd0, 2'd1};
        h_uns  = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            ref_req(1'b0, h_addr[i], h_size[i], h_uns[i], 32'd0, 1'b1, ref_mem[int'(h_addr[i][7:2])],
                    e_err, h_exp[i], e_new, e_lat);
            h_tacc[i] = 0;
            h_trsp[i] = 0;
        end
        acc = 0; got = 0; rdy_cnt = 0;
        @(negedge clk);
        set_req(1'b1, 1'b0, 1'b0, h_addr[0], h_size[0], h_uns[0], 32'd0);
        for (int t = 0; t < 20 && got < 3; t++) begin
            if (if_a.rsp_valid) begin
                check_val("held_rdata", if_a.rsp_rdata, h_exp[got]);
                h_trsp[got] = t;
                got++;
            end
            if (if_a.req_ready) rdy_cnt++;
            take = (acc < 3) && if_a.req_ready;
            if (take) h_tacc[acc] = t;
            @(posedge clk);
            #1;
            if (take) begin
                acc++;
                if (acc < 3) set_req(1'b1, 1'b0, 1'b0, h_addr[acc], h_size[acc], h_uns[acc], 32'd0);
                else if_a.req_valid = 1'b0;
            end
            @(negedge clk);
        end
        check_val("held_acc", 32'(acc), 32'd3);
        check_val("held_rsp", 32'(got), 32'd3);
        check_val("held_ready_cnt", 32'(rdy_cnt), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check_val("held_lat", 32'(h_trsp[i] - h_tacc[i]), 32'd2);
            check_val("held_spacing", 32'(h_tacc[i] - h_tacc[0]), 32'(3 * i));
        end

        for (int n = 0; n < 60; n++) begin
            run_req(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), $urandom, rd);
        end

        @(negedge clk);
        for (int i = 0; i < 64; i++) check_val("mem_final", mem_env[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
Initiator side of the core0 word-addressed data-memory interface. Accepts byte, halfword and word load/store requests from the execute stage over a valid/ready handshake. Converts each request into accesses on the memory port: address, write_data, w_en, and a combinational read_data return. Sub-word stores are done as read-modify-write. Loads are sign- or zero-extended. Misaligned or reserved-size requests are rejected before any memory access.

Parameters:
STORE_RMW, 1, 1: sub-word stores use read-modify-write; 0: sub-word stores return rsp_err with no memory access.

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
req_valid  input  1  request present
req_ready  output  1  block can accept a request (IDLE only)
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  input  1  zero-extend load (LBU/LHU)
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_err  output  1  misaligned or reserved size; valid with rsp_valid
mem_address  output  32  word-aligned address to memory
mem_write_data  output  32  full word to write
mem_w_en  output  1  memory write strobe
mem_read_data  input  32  combinational memory read data

Behaviour:
- Reset: state IDLE. rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_w_en=0, mem_address=0, mem_write_data=0. req_ready=1 from the first cycle after reset.
- mem_w_en is ANDed with rst_n. No write may occur in any cycle where rst_n=0.
- Handshake: a request is accepted on a clk edge with req_valid && req_ready. All request fields are latched at that edge. req_ready=0 in every state except IDLE. rsp has no backpressure.
- Alignment check at accept:
  - half requires addr[0]=0
  - word requires addr[1:0]=00
  - size 11 is always an error
  - with STORE_RMW=0, any sub-word store is an error
- FSM states: IDLE, ACCESS, RMW_READ, RMW_WRITE, RESP.
  - IDLE: accept. On error go to RESP with err. Load or word store goes to ACCESS. Sub-word store goes to RMW_READ.
  - ACCESS: mem_address={addr[31:2],2'b00}. For a store, mem_w_en=1 and mem_write_data=wdata. For a load, the extracted lane is captured into the rdata register. Then RESP.
  - RMW_READ: the same address is driven with mem_w_en=0. mem_read_data is captured into the merge register. Then RMW_WRITE.
  - RMW_WRITE: mem_w_en=1. mem_write_data is the merge word with the byte lane (addr[1:0]) or half lane (addr[1]) replaced by wdata[7:0] or wdata[15:0]. Then RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Latency (request accepted at edge 0):
  - load / word store: rsp_valid high in cycle 2
  - sub-word store: rsp_valid high in cycle 3
  - error: rsp_valid high in cycle 1
- Each request produces exactly one mem_w_en cycle for a store and none for a load or error.
- Byte-lane extraction: lane k = read_data[8k+7:8k]. Half lane = read_data[16·addr[1]+15 : 16·addr[1]]. Sign extension uses the lane MSB unless req_unsigned=1.
- rsp_rdata and rsp_err are registered. They hold their value until the next RESP.
- mem_address holds the last aligned address outside access states. mem_w_en=0 outside ACCESS-store and RMW_WRITE.
- A new request may be accepted in the cycle after RESP, giving back-to-back throughput of one request per 3 cycles (4 for sub-word stores).
- Reset mid-operation: the block returns to IDLE next edge. The in-flight request is dropped, no response is issued, and no write occurs, including when reset lands in RMW_READ.

Decomposition:
- Package lsu_pkg:
  - size_e (SZ_B, SZ_H, SZ_W, SZ_RSV)
  - state_e
  - function is_misaligned(size, addr[1:0])
- Sub-module lsu_byte_lane (combinational): load extract/extend and store merge. Top level keeps the FSM and registers.

Test Plan:
- Word 0x10 preloaded with 0x8899AABB.
  - LB 0x13 signed -> rsp cycle 2, rdata 0xFFFFFF88, err 0.
  - LBU 0x12 -> rdata 0x00000099.
  - LH 0x12 -> rdata 0xFFFF8899.
- SB 0x11 wdata 0x123456CC -> mem_w_en exactly one cycle (cycle 2), write_data 0x8899CCBB, rsp cycle 3. A following LW 0x10 returns 0x8899CCBB.
- SW 0x20 0xDEADBEEF -> mem_address 0x20, w_en in cycle 1, rsp cycle 2. A following LW returns 0xDEADBEEF.
- LH 0x11, then SW 0x22, then size 11 -> each gives rsp_err=1 in cycle 1, rdata 0, and mem_w_en never asserts.
- SH 0x12: assert rst_n=0 during RMW_READ -> no mem_w_en, no rsp_valid, req_ready=1 after release. With STORE_RMW=0, SH returns err.
- req_valid held high with 3 loads -> req_ready low except in IDLE, each accepted once, responses in order.
